// File: rtl/dp_pkg.sv
// Shared constants and FSM encoding for the dot-product accumulate stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package dp_pkg;
  localparam int DATA_W_DFLT  = 16;
  localparam int ACC_W_DFLT   = 32;
  localparam int VEC_LEN_DFLT = 8;
  localparam int CNT_W        = $clog2(VEC_LEN_DFLT + 1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;
endpackage

// File: rtl/adder.sv
// Unsigned W-bit adder with carry-out; wraps modulo 2^W.
// Latency: combinational.
// Backpressure: n/a.
module adder #(
  parameter int W = 32
) (
  input  logic [W-1:0] ain,
  input  logic [W-1:0] bin,
  output logic [W-1:0] dout,
  output logic         overflow
);
  // Extend by one bit so the carry-out lands in overflow.
  always_comb begin
    {overflow, dout} = {1'b0, ain} + {1'b0, bin};
  end
endmodule

// File: rtl/dot_product_acc.sv
// Streaming MAC: VEC_LEN unsigned operand pairs -> one dot product + sticky carry flag.
// Latency: result valid one edge after the edge that accepts the last pair.
// Backpressure: in_ready drops after VEC_LEN accepts and stays low until the result is taken.
module dot_product_acc
  import dp_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DFLT,
  parameter int ACC_W   = ACC_W_DFLT,
  parameter int VEC_LEN = VEC_LEN_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  dout,
  output logic              overflow
);
  localparam int CNT_BITS = $clog2(VEC_LEN + 1);

  state_t              state_q, state_d;
  logic [ACC_W-1:0]    prod_q, prod_d;
  logic                prod_v_q, prod_v_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;

  logic                in_xfer;
  logic [ACC_W-1:0]    sum;
  logic                carry;

  adder #(.W(ACC_W)) u_adder (
    .ain      (acc_q),
    .bin      (prod_q),
    .dout     (sum),
    .overflow (carry)
  );

  // Handshake outputs; both are pure functions of registered state.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    dout      = '0;
    overflow  = 1'b0;
    if (state_q == ST_ACCUM) begin
      in_ready = (cnt_q < CNT_BITS'(VEC_LEN));
    end else begin
      out_valid = 1'b1;
      dout      = acc_q;
      overflow  = ovf_q;
    end
  end

  assign in_xfer = in_valid && in_ready;

  // Stage 1: register the product of each accepted pair; the product always fits ACC_W.
  always_comb begin
    prod_d   = prod_q;
    prod_v_d = in_xfer;
    if (in_xfer) begin
      prod_d = ACC_W'(a_in) * ACC_W'(b_in);
    end
  end

  // Stage 2 and FSM: accumulate, count accepts, hold the result until it is taken.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (in_xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (prod_v_q) begin
      acc_d = sum;
      ovf_d = ovf_q | carry;
    end
    case (state_q)
      ST_ACCUM: begin
        if (prod_v_q && (cnt_q == CNT_BITS'(VEC_LEN))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
  end

  // State registers; reset discards any partial sum and in-flight product.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_ACCUM;
      prod_q   <= '0;
      prod_v_q <= 1'b0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      prod_v_q <= prod_v_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
    end
  end
endmodule

// File: tb/tb_dot_product_acc.sv
// Scoreboard bench for dot_product_acc: driver pushes reference results, monitor pops on output transfers.
// Latency: checks result arrives one edge after the last accept.
// Backpressure: exercises out_ready stalls, input bubbles and mid-vector reset.
module tb_dot_product_acc;
  localparam int VEC = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] dout;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;
  int n_out   = 0;
  int n_push  = 0;
  logic [32:0] exp_q[$];

  dot_product_acc dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: an output transfer happens at the next rising edge when both are high here.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", {31'd0, overflow, dout}, 64'hDEAD);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result_dout", 64'(dout), 64'(e[31:0]));
        check("result_overflow", 64'(overflow), 64'(e[32]));
      end
    end
  end

  // Present one pair and hold it until accepted (bounded).
  task automatic offer(input logic [15:0] a, input logic [15:0] b);
    int waitc;
    waitc    = 0;
    a_in     = a;
    b_in     = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waitc < 200) begin
      @(negedge clk);
      waitc++;
    end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send a full vector; reference result is the plain integer sum of products.
  task automatic send_vector(input logic [15:0] av[VEC], input logic [15:0] bv[VEC], input bit bubbles);
    logic [63:0] total;
    total = 64'd0;
    for (int i = 0; i < VEC; i++) begin
      if (bubbles) begin
        for (int k = 0; k < 4 && $urandom_range(1) == 1; k++) begin
          in_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      offer(av[i], bv[i]);
      total = total + 64'(av[i]) * 64'(bv[i]);
    end
    exp_q.push_back({(total >= 64'h1_0000_0000), total[31:0]});
    n_push++;
  endtask

  task automatic wait_out_valid(string name);
    int waitc;
    waitc = 0;
    while (!out_valid && waitc < 50) begin
      @(posedge clk);
      #1;
      waitc++;
    end
    if (!out_valid) check(name, 64'(out_valid), 64'd1);
  endtask

  logic [15:0] a1[VEC], b1[VEC], af[VEC], a2[VEC], a_one[VEC], ar[VEC], br[VEC];
  int n0;

  initial begin
    for (int i = 0; i < VEC; i++) begin
      a1[i]    = 16'(i);
      b1[i]    = 16'(i + 1);
      af[i]    = 16'hFFFF;
      a2[i]    = 16'd2;
      a_one[i] = 16'd1;
    end
    rst       = 1'b1;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    out_ready = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_overflow", 64'(overflow), 64'd0);
    #21;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic vector with latency check
    send_vector(a1, b1, 1'b0);
    check("t1_no_valid_at_last_accept", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("t1_valid_one_edge_later", 64'(out_valid), 64'd1);
    repeat (2) @(posedge clk);
    #1;

    // 2: overflow, then sticky flag cleared by the next vector
    send_vector(af, af, 1'b0);
    send_vector(a_one, a_one, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // 3: bubbles, then a ninth pair must be refused until the result is taken
    out_ready = 1'b0;
    send_vector(a1, b1, 1'b1);
    wait_out_valid("t3_out_valid_timeout");
    a_in     = 16'd7;
    b_in     = 16'd7;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_ninth_refused", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // 4: backpressure holds the result stable
    out_ready = 1'b0;
    send_vector(a1, b1, 1'b0);
    wait_out_valid("t4_out_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold_valid", 64'(out_valid), 64'd1);
      check("t4_hold_dout", 64'(dout), 64'd168);
      check("t4_hold_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    n0        = n_out;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t4_one_transfer", 64'(n_out - n0), 64'd1);
    check("t4_valid_cleared", 64'(out_valid), 64'd0);
    check("t4_in_ready_back", 64'(in_ready), 64'd1);

    // 5: async reset after three accepts discards the partial sum
    offer(16'd100, 16'd100);
    offer(16'd200, 16'd200);
    offer(16'd300, 16'd300);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", 64'(out_valid), 64'd0);
    check("t5_rst_dout", 64'(dout), 64'd0);
    check("t5_rst_overflow", 64'(overflow), 64'd0);
    check("t5_rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    send_vector(a2, a2, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // 6: back-to-back vectors
    n0 = n_out;
    send_vector(a1, b1, 1'b0);
    send_vector(a2, a2, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("t6_two_results", 64'(n_out - n0), 64'd2);

    // Random vectors with random bubbles
    for (int v = 0; v < 4; v++) begin
      for (int i = 0; i < VEC; i++) begin
        ar[i] = 16'($urandom);
        br[i] = 16'($urandom);
      end
      send_vector(ar, br, 1'b1);
    end

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    check("result_count", 64'(n_out), 64'(n_push));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
